// File: rtl/bird_collision_if.sv
// Game-control bus for bird_collision: per-frame game inputs in, game status out.
//   master (game top / bench) : drives tick, birdRow, pipeCol, pipePass, start
//                               reads lossDetect, playing, score, hiScore
//   slave  (bird_collision)   : the reverse
interface bird_collision_if;
    localparam int unsigned ROW_W   = 16;
    localparam int unsigned SCORE_W = 8;

    logic               tick;
    logic [ROW_W-1:0]   birdRow;
    logic [ROW_W-1:0]   pipeCol;
    logic               pipePass;
    logic               start;
    logic               lossDetect;
    logic               playing;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] hiScore;

    modport master (
        output tick, birdRow, pipeCol, pipePass, start,
        input  lossDetect, playing, score, hiScore
    );

    modport slave (
        input  tick, birdRow, pipeCol, pipePass, start,
        output lossDetect, playing, score, hiScore
    );
endinterface

// File: rtl/bird_collision.sv
// Flappy-bird game controller: collision detection, BCD scoring, high score,
// and a post-death grace period before a restart is accepted.
// Ports:
//   clock  - system clock, all state updates on its rising edge
//   reset  - synchronous active-high reset, clears all state
//   bus    - bird_collision_if.slave
//            in : tick, birdRow[15:0], pipeCol[15:0], pipePass, start
//            out: lossDetect, playing, score[7:0] (BCD), hiScore[7:0] (BCD)
module bird_collision (
    input  logic              clock,
    input  logic              reset,
    bird_collision_if.slave   bus
);
    localparam int unsigned ROW_W   = 16;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned GRACE_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_start_q;
    logic [GRACE_W-1:0] r_grace;
    logic [GRACE_W-1:0] w_grace_nxt;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_score_nxt;
    logic [SCORE_W-1:0] r_hi_score;
    logic [SCORE_W-1:0] w_hi_score_nxt;
    logic               r_loss;
    logic               w_loss_nxt;
    logic               r_playing;
    logic               w_playing_nxt;

    logic               w_start_edge;
    logic [ROW_W-1:0]   w_row_m1;
    logic               w_multi_bit;
    logic               w_collision;
    logic               w_pass;

    // Two-digit BCD increment, saturating at 99.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] res;
        if (v == SCORE_W'(8'h99)) begin
            res = v;
        end else if (v[3:0] == 4'd9) begin
            res = {v[7:4] + 4'd1, 4'd0};
        end else begin
            res = {v[7:4], v[3:0] + 4'd1};
        end
        return res;
    endfunction

    // Rising edge of the flap key.
    assign w_start_edge = bus.start & ~r_start_q;

    // x & (x-1) is non-zero exactly when more than one bit is set.
    assign w_row_m1    = bus.birdRow - ROW_W'(1);
    assign w_multi_bit = |(bus.birdRow & w_row_m1);

    // Collisions only count on game-update ticks while playing.
    assign w_collision = (r_state == S_PLAY) && bus.tick &&
                         ((|(bus.birdRow & bus.pipeCol)) ||
                          (bus.birdRow == '0) ||
                          w_multi_bit);

    // Collision in the same cycle cancels the pass.
    assign w_pass = (r_state == S_PLAY) && bus.pipePass && !w_collision;

    // State register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_grace    <= '0;
            r_score    <= '0;
            r_hi_score <= '0;
            r_loss     <= 1'b0;
            r_playing  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_start_q  <= bus.start;
            r_grace    <= w_grace_nxt;
            r_score    <= w_score_nxt;
            r_hi_score <= w_hi_score_nxt;
            r_loss     <= w_loss_nxt;
            r_playing  <= w_playing_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_start_edge) w_state_nxt = S_PLAY;
            S_PLAY: if (w_collision)  w_state_nxt = S_DEAD;
            S_DEAD: if (w_start_edge && (r_grace == GRACE_W'(3))) w_state_nxt = S_PLAY;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, score and grace counter.
    always_comb begin
        w_score_nxt    = r_score;
        w_hi_score_nxt = r_hi_score;
        w_grace_nxt    = r_grace;
        w_loss_nxt     = (w_state_nxt == S_DEAD);
        w_playing_nxt  = (w_state_nxt == S_PLAY);

        unique case (r_state)
            S_IDLE: begin
                if (w_state_nxt == S_PLAY) w_score_nxt = '0;
            end
            S_PLAY: begin
                if (w_pass) w_score_nxt = bcd_inc(r_score);
                if (w_state_nxt == S_DEAD) begin
                    w_grace_nxt = '0;
                    // BCD digits order the same as plain unsigned bytes.
                    if (w_score_nxt > r_hi_score) w_hi_score_nxt = w_score_nxt;
                end
            end
            S_DEAD: begin
                if (w_state_nxt == S_PLAY) begin
                    w_score_nxt = '0;
                end else if (bus.tick && (r_grace != GRACE_W'(3))) begin
                    w_grace_nxt = r_grace + GRACE_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.lossDetect = r_loss;
    assign bus.playing    = r_playing;
    assign bus.score      = r_score;
    assign bus.hiScore    = r_hi_score;

endmodule

// File: tb/tb_bird_collision.sv
// Directed self-checking bench for bird_collision.
module tb_bird_collision;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    bird_collision_if bus ();

    bird_collision dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge; sample 1 time unit later.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic loss, input logic play,
                              input logic [7:0] sc, input logic [7:0] hi);
        chk({tag, "_loss"},  8'(bus.lossDetect), 8'(loss));
        chk({tag, "_play"},  8'(bus.playing),    8'(play));
        chk({tag, "_score"}, bus.score,          sc);
        chk({tag, "_hi"},    bus.hiScore,        hi);
    endtask

    logic [7:0] exp_bcd [12];

    initial begin
        checks = 0;
        errors = 0;
        exp_bcd = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                    8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};

        reset        = 1'b1;
        bus.tick     = 1'b0;
        bus.birdRow  = 16'h0010;
        bus.pipeCol  = 16'h0000;
        bus.pipePass = 1'b0;
        bus.start    = 1'b0;
        cyc();
        cyc();
        chk_status("reset", 1'b0, 1'b0, 8'h00, 8'h00);
        reset = 1'b0;

        // Passes and safe ticks in IDLE do nothing.
        bus.pipePass = 1'b1;
        bus.tick     = 1'b1;
        cyc();
        bus.pipePass = 1'b0;
        bus.tick     = 1'b0;
        chk_status("idle_ignore", 1'b0, 1'b0, 8'h00, 8'h00);

        // Start game.
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk_status("start1", 1'b0, 1'b1, 8'h00, 8'h00);

        // Twelve passes, checking every BCD step including 09 -> 10.
        for (int i = 0; i < 12; i++) begin
            bus.pipePass = 1'b1;
            cyc();
            chk("pass_cnt", bus.score, exp_bcd[i]);
        end
        bus.pipePass = 1'b0;

        // Safe tick keeps playing.
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        chk_status("safe_tick", 1'b0, 1'b1, 8'h12, 8'h00);

        // Overlap collision.
        bus.pipeCol = 16'hFF10;
        bus.tick    = 1'b1;
        cyc();
        bus.tick    = 1'b0;
        bus.pipeCol = 16'h0000;
        chk_status("hit_overlap", 1'b1, 1'b0, 8'h12, 8'h12);

        // Pass while dead is ignored.
        bus.pipePass = 1'b1;
        cyc();
        bus.pipePass = 1'b0;
        chk_status("dead_pass", 1'b1, 1'b0, 8'h12, 8'h12);

        // One tick, then start edge: too early, discarded.
        bus.tick = 1'b1;
        cyc();
        bus.tick  = 1'b0;
        bus.start = 1'b1;
        cyc();
        chk_status("grace_early", 1'b1, 1'b0, 8'h12, 8'h12);
        // Hold start high across grace expiry: no restart.
        bus.tick = 1'b1;
        cyc();
        cyc();
        bus.tick = 1'b0;
        cyc();
        chk_status("grace_held", 1'b1, 1'b0, 8'h12, 8'h12);
        // Fresh edge after grace restarts.
        bus.start = 1'b0;
        cyc();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk_status("restart1", 1'b0, 1'b1, 8'h00, 8'h12);

        // One pass, then reset mid-PLAY with every other input active.
        bus.pipePass = 1'b1;
        cyc();
        chk("mid_pass", bus.score, 8'h01);
        reset     = 1'b1;
        bus.tick  = 1'b1;
        bus.start = 1'b1;
        bus.birdRow = 16'h0000;
        cyc();
        chk_status("reset_mid", 1'b0, 1'b0, 8'h00, 8'h00);
        reset        = 1'b0;
        bus.tick     = 1'b0;
        bus.start    = 1'b0;
        bus.pipePass = 1'b0;
        bus.birdRow  = 16'h0010;
        cyc();
        chk_status("post_reset", 1'b0, 1'b0, 8'h00, 8'h00);

        // New game to score 05, then pass and collision together.
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk_status("start2", 1'b0, 1'b1, 8'h00, 8'h00);
        bus.pipePass = 1'b1;
        repeat (5) cyc();
        chk("five", bus.score, 8'h05);
        bus.tick    = 1'b1;
        bus.pipeCol = 16'hFF10;
        cyc();
        bus.tick     = 1'b0;
        bus.pipePass = 1'b0;
        bus.pipeCol  = 16'h0000;
        chk_status("pass_and_hit", 1'b1, 1'b0, 8'h05, 8'h05);

        // Three ticks then restart.
        bus.tick = 1'b1;
        repeat (3) cyc();
        bus.tick  = 1'b0;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk_status("restart2", 1'b0, 1'b1, 8'h00, 8'h05);

        // Overlap without tick is not a collision.
        bus.pipeCol = 16'hFF10;
        cyc();
        bus.pipeCol = 16'h0000;
        chk_status("no_tick", 1'b0, 1'b1, 8'h00, 8'h05);

        // Two bird bits lit is a collision; lower score leaves hiScore alone.
        bus.birdRow = 16'h0030;
        bus.tick    = 1'b1;
        cyc();
        bus.tick    = 1'b0;
        bus.birdRow = 16'h0010;
        chk_status("hit_multi", 1'b1, 1'b0, 8'h00, 8'h05);

        bus.tick = 1'b1;
        repeat (3) cyc();
        bus.tick  = 1'b0;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk_status("restart3", 1'b0, 1'b1, 8'h00, 8'h05);

        // Saturation at 99.
        bus.pipePass = 1'b1;
        repeat (99) cyc();
        chk("score99", bus.score, 8'h99);
        cyc();
        bus.pipePass = 1'b0;
        chk("sat99", bus.score, 8'h99);

        // Bird off the matrix is a collision.
        bus.birdRow = 16'h0000;
        bus.tick    = 1'b1;
        cyc();
        bus.tick    = 1'b0;
        bus.birdRow = 16'h0010;
        chk_status("hit_off", 1'b1, 1'b0, 8'h99, 8'h99);

        // Final reset from DEAD.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_status("reset_dead", 1'b0, 1'b0, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
